// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the RV32I front end: default datapath width, the
//   canonical NOP word, the layout of one prefetch-queue entry and the bit
//   positions of the rs1/rs2 register fields. Decode and the hazard unit
//   import the same field positions so all three agree on the encoding.
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 - presented to decode whenever the queue has nothing to offer
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Register source fields inside a 32-bit RV32I instruction word
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  // One prefetch-queue entry; packed so it maps directly onto a FIFO word
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcp4;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with DEPTH-modulo read/write pointers and an explicit
//   occupancy counter. The head word is read straight from storage (no
//   output register), so a word pushed at edge N is visible after edge N.
//
// Ports
//   clk    in   clock
//   rst    in   synchronous active-high reset, empties the FIFO
//   push   in   write wdata at the tail (ignored when full without a pop)
//   pop    in   drop the head word (ignored when empty)
//   clear  in   flush all contents; overrides push and pop
//   wdata  in   tail write data
//   rdata  out  head word (stale contents when empty)
//   count  out  occupancy, 0..DEPTH
//   empty  out  count == 0
//   full   out  count == DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A push into a full FIFO is only legal when the head leaves in the same
  // cycle; the guards make over/underflow impossible regardless of callers.
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state for storage, pointers and occupancy. DEPTH is a power of two,
  // so the pointers wrap naturally at their bit width.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state is reset; payload storage needs no reset because nothing
  // reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end. Issues sequential fetches to instruction
//   memory, buffers {pc, pc+4, instr} entries in a prefetch queue and serves
//   them to decode with a valid/ready handshake. Early (ID) and late (MEM)
//   redirects flush the queue and restart fetching at the target.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   iaddr / ireq        fetch address (the fetch PC) and request
//   iready_n / idata    active-low memory ready and returned instruction
//   redir_early_*       ID-stage redirect
//   redir_late_*        MEM-stage redirect, wins over the early one
//   out_valid/out_ready head handshake towards decode
//   out_instr/pc/pcp4   head entry (NOP_INSTR / 0 when nothing is valid)
//   out_rs1/out_rs2     register fields of out_instr for the hazard unit
//   count               queue occupancy
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int              XLEN      = core_pkg::XLEN,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        iaddr,
  output logic                   ireq,
  input  logic                   iready_n,
  input  logic [31:0]            idata,
  input  logic                   redir_early_valid,
  input  logic [XLEN-1:0]        redir_early_pc,
  input  logic                   redir_late_valid,
  input  logic [XLEN-1:0]        redir_late_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_pcp4,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [$clog2(DEPTH):0] count
);

  import core_pkg::*;

  localparam int FW = 2*XLEN + 32;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] redir_target;
  logic            redirect;
  logic            pop;
  logic            accept;
  logic            fifo_empty, fifo_full;
  logic [FW-1:0]   push_data, head_data;
  logic [XLEN-1:0] head_pc, head_pcp4;
  logic [31:0]     head_instr;

  // Late redirect overrides early; targets are forced word-aligned.
  assign redirect = redir_late_valid | redir_early_valid;
  always_comb begin
    redir_target = redir_late_valid ? redir_late_pc : redir_early_pc;
    redir_target = {redir_target[XLEN-1:2], 2'b00};
  end

  // The head is only offered outside reset; a pop needs an actual entry.
  assign out_valid = !rst & !fifo_empty;
  assign pop       = out_valid & out_ready;

  // A fetch is requested whenever there is (or will be, via a pop) room.
  // Redirect cycles fetch nothing: the target is fetched the cycle after.
  assign ireq   = !rst & !redirect & (!fifo_full | pop);
  assign accept = ireq & !iready_n;
  assign iaddr  = fetch_pc_q;

  assign push_data = {fetch_pc_q, fetch_pc_q + XLEN'(4), idata};

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop & !redirect),
    .clear (redirect),
    .wdata (push_data),
    .rdata (head_data),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign {head_pc, head_pcp4, head_instr} = head_data;

  // Decode sees a NOP and zero PCs whenever the head is not valid, so stale
  // storage contents never leak into the pipeline.
  assign out_instr = out_valid ? head_instr : NOP_INSTR;
  assign out_pc    = out_valid ? head_pc    : '0;
  assign out_pcp4  = out_valid ? head_pcp4  : '0;
  assign out_rs1   = out_instr[RS1_MSB:RS1_LSB];
  assign out_rs2   = out_instr[RS2_MSB:RS2_LSB];

  // Fetch PC: redirect target wins, otherwise advance by one word on each
  // accepted fetch (wraps modulo 2^XLEN), otherwise hold for the memory.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redir_target;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule
